// File: rtl/matrix_scan_bcm.sv
// rtl/matrix_scan_bcm.sv - HUB75 LED matrix scan generator with binary-coded modulation
module matrix_scan_bcm #(
    parameter int COLUMNS      = 64,
    parameter int ROW_BITS     = 4,
    parameter int BCM_BITS     = 6,
    parameter int OE_UNIT      = 1,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                       clk_in,
    input  logic                       reset,
    output logic [$clog2(COLUMNS)-1:0] column_address,
    output logic [ROW_BITS-1:0]        row_address,
    output logic [BCM_BITS-1:0]        brightness_mask,
    output logic [ROW_BITS-1:0]        display_row,
    output logic                       clk_pixel_en,
    output logic                       row_latch_en,
    output logic                       output_enable,
    output logic                       frame_start
);

    localparam int COL_W   = $clog2(COLUMNS);
    localparam int DISP_W  = $clog2(OE_UNIT) + BCM_BITS + 1;
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLUMNS - 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {ST_SHIFT, ST_WAIT, ST_BLANK, ST_LATCH} state_t;

    state_t              state;
    logic [DISP_W-1:0]   disp_cnt;
    logic [DISP_W-1:0]   disp_next;
    logic [DISP_W-1:0]   plane_time;
    logic [BLANK_W-1:0]  blank_cnt;

    // Remaining on-time after the current cycle; a lit cycle consumes one unit
    always_comb begin
        disp_next = output_enable ? disp_cnt - DISP_W'(1) : disp_cnt;
    end

    // On-time of the plane about to be latched: OE_UNIT scaled by its bit weight
    always_comb begin
        plane_time = '0;
        for (int i = 0; i < BCM_BITS; i++) begin
            if (brightness_mask[i]) begin
                plane_time = DISP_W'(OE_UNIT) << i;
            end
        end
    end

    // Scan sequencer: every output is a register describing the current cycle
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state           <= ST_SHIFT;
            column_address  <= COL_LAST;
            row_address     <= '0;
            display_row     <= '0;
            brightness_mask <= BCM_BITS'(1);
            disp_cnt        <= '0;
            blank_cnt       <= '0;
            clk_pixel_en    <= 1'b0;
            row_latch_en    <= 1'b0;
            output_enable   <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            row_latch_en <= 1'b0;
            frame_start  <= 1'b0;
            case (state)
                ST_SHIFT: begin
                    disp_cnt      <= disp_next;
                    output_enable <= (disp_next != '0);
                    if (!clk_pixel_en) begin
                        // Only seen right after reset: start shifting at the last column
                        clk_pixel_en <= 1'b1;
                    end else if (column_address != '0) begin
                        column_address <= column_address - COL_W'(1);
                    end else begin
                        clk_pixel_en <= 1'b0;
                        if (disp_next == '0) begin
                            state         <= ST_BLANK;
                            blank_cnt     <= BLANK_LOAD;
                            output_enable <= 1'b0;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    disp_cnt <= disp_next;
                    if (disp_next == '0) begin
                        state         <= ST_BLANK;
                        blank_cnt     <= BLANK_LOAD;
                        output_enable <= 1'b0;
                    end else begin
                        output_enable <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    output_enable <= 1'b0;
                    if (blank_cnt == '0) begin
                        state        <= ST_LATCH;
                        row_latch_en <= 1'b1;
                        frame_start  <= (row_address == '0) && (brightness_mask == BCM_BITS'(1));
                    end else begin
                        blank_cnt <= blank_cnt - BLANK_W'(1);
                    end
                end
                ST_LATCH: begin
                    state          <= ST_SHIFT;
                    display_row    <= row_address;
                    disp_cnt       <= plane_time;
                    output_enable  <= (plane_time != '0);
                    clk_pixel_en   <= 1'b1;
                    column_address <= COL_LAST;
                    // A corrupted mask restarts at plane 0 of the same row
                    if (!$onehot(brightness_mask)) begin
                        brightness_mask <= BCM_BITS'(1);
                    end else if (brightness_mask[BCM_BITS-1]) begin
                        brightness_mask <= BCM_BITS'(1);
                        row_address     <= row_address + ROW_BITS'(1);
                    end else begin
                        brightness_mask <= brightness_mask << 1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_bcm.sv
// tb/tb_matrix_scan_bcm.sv - self-checking bench for matrix_scan_bcm
module tb_matrix_scan_bcm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int sel = 0;

    // Instance 0: defaults
    logic [5:0] d0_col; logic [3:0] d0_row; logic [5:0] d0_mask; logic [3:0] d0_drow;
    logic d0_pix, d0_lat, d0_oe, d0_fs;
    // Instance 1: OE_UNIT=128
    logic [5:0] d1_col; logic [3:0] d1_row; logic [5:0] d1_mask; logic [3:0] d1_drow;
    logic d1_pix, d1_lat, d1_oe, d1_fs;
    // Instance 2: ROW_BITS=2, BCM_BITS=2
    logic [5:0] d2_col; logic [1:0] d2_row; logic [1:0] d2_mask; logic [1:0] d2_drow;
    logic d2_pix, d2_lat, d2_oe, d2_fs;
    // Instance 3: COLUMNS=32, BLANK_CYCLES=3
    logic [4:0] d3_col; logic [3:0] d3_row; logic [5:0] d3_mask; logic [3:0] d3_drow;
    logic d3_pix, d3_lat, d3_oe, d3_fs;

    matrix_scan_bcm u_d0 (
        .clk_in(clk), .reset(rst), .column_address(d0_col), .row_address(d0_row),
        .brightness_mask(d0_mask), .display_row(d0_drow), .clk_pixel_en(d0_pix),
        .row_latch_en(d0_lat), .output_enable(d0_oe), .frame_start(d0_fs)
    );
    matrix_scan_bcm #(.OE_UNIT(128)) u_d1 (
        .clk_in(clk), .reset(rst), .column_address(d1_col), .row_address(d1_row),
        .brightness_mask(d1_mask), .display_row(d1_drow), .clk_pixel_en(d1_pix),
        .row_latch_en(d1_lat), .output_enable(d1_oe), .frame_start(d1_fs)
    );
    matrix_scan_bcm #(.ROW_BITS(2), .BCM_BITS(2)) u_d2 (
        .clk_in(clk), .reset(rst), .column_address(d2_col), .row_address(d2_row),
        .brightness_mask(d2_mask), .display_row(d2_drow), .clk_pixel_en(d2_pix),
        .row_latch_en(d2_lat), .output_enable(d2_oe), .frame_start(d2_fs)
    );
    matrix_scan_bcm #(.COLUMNS(32), .BLANK_CYCLES(3)) u_d3 (
        .clk_in(clk), .reset(rst), .column_address(d3_col), .row_address(d3_row),
        .brightness_mask(d3_mask), .display_row(d3_drow), .clk_pixel_en(d3_pix),
        .row_latch_en(d3_lat), .output_enable(d3_oe), .frame_start(d3_fs)
    );

    int m_col, m_row, m_mask, m_drow;
    bit m_pix, m_lat, m_oe, m_fs;

    // Observe the instance under test through one common set of signals
    always_comb begin
        m_col = 0; m_row = 0; m_mask = 0; m_drow = 0;
        m_pix = 1'b0; m_lat = 1'b0; m_oe = 1'b0; m_fs = 1'b0;
        case (sel)
            0: begin m_col = int'(d0_col); m_row = int'(d0_row); m_mask = int'(d0_mask); m_drow = int'(d0_drow);
                     m_pix = d0_pix; m_lat = d0_lat; m_oe = d0_oe; m_fs = d0_fs; end
            1: begin m_col = int'(d1_col); m_row = int'(d1_row); m_mask = int'(d1_mask); m_drow = int'(d1_drow);
                     m_pix = d1_pix; m_lat = d1_lat; m_oe = d1_oe; m_fs = d1_fs; end
            2: begin m_col = int'(d2_col); m_row = int'(d2_row); m_mask = int'(d2_mask); m_drow = int'(d2_drow);
                     m_pix = d2_pix; m_lat = d2_lat; m_oe = d2_oe; m_fs = d2_fs; end
            default: begin m_col = int'(d3_col); m_row = int'(d3_row); m_mask = int'(d3_mask); m_drow = int'(d3_drow);
                     m_pix = d3_pix; m_lat = d3_lat; m_oe = d3_oe; m_fs = d3_fs; end
        endcase
    end

    typedef struct {
        int cyc;
        int row;
        int mask;
        bit fs;
        int oe_prev;
        bit exact;
    } latch_t;

    latch_t exp_q[$];

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (m_pix !== 1'b0) begin miscompares++; $display("FAIL reset_pix got %0d expected 0", m_pix); end
        vectors++; if (m_lat !== 1'b0) begin miscompares++; $display("FAIL reset_latch got %0d expected 0", m_lat); end
        vectors++; if (m_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %0d expected 0", m_oe); end
        vectors++; if (m_fs !== 1'b0) begin miscompares++; $display("FAIL reset_fs got %0d expected 0", m_fs); end
        vectors++; if (m_col !== 63) begin miscompares++; $display("FAIL reset_col got %0d expected 63", m_col); end
        vectors++; if (m_row !== 0) begin miscompares++; $display("FAIL reset_row got %0d expected 0", m_row); end
        vectors++; if (m_drow !== 0) begin miscompares++; $display("FAIL reset_drow got %0d expected 0", m_drow); end
        vectors++; if (m_mask !== 1) begin miscompares++; $display("FAIL reset_mask got %0d expected 1", m_mask); end
    endtask

    // Default instance: first plane timing from cycle 0 (first cycle out of reset)
    task automatic test_first_plane(input bit do_reset);
        sel = 0;
        if (do_reset) reset_dut();
        for (int c = 0; c <= 66; c++) begin
            @(negedge clk);
            vectors++;
            if (m_pix !== ((c <= 63) || (c == 66))) begin
                miscompares++; $display("FAIL first_pix cycle %0d got %0d", c, m_pix);
            end
            if (c <= 63) begin
                vectors++;
                if (m_col !== 63 - c) begin
                    miscompares++; $display("FAIL first_col cycle %0d got %0d expected %0d", c, m_col, 63 - c);
                end
            end
            vectors++;
            if (m_oe !== (c == 66)) begin
                miscompares++; $display("FAIL first_oe cycle %0d got %0d expected %0d", c, m_oe, (c == 66));
            end
            vectors++;
            if (m_lat !== (c == 65)) begin
                miscompares++; $display("FAIL first_latch cycle %0d got %0d expected %0d", c, m_lat, (c == 65));
            end
            vectors++;
            if (m_fs !== (c == 65)) begin
                miscompares++; $display("FAIL first_fs cycle %0d got %0d expected %0d", c, m_fs, (c == 65));
            end
            if (c == 66) begin
                vectors++;
                if (m_mask !== 2) begin
                    miscompares++; $display("FAIL first_mask cycle %0d got %0d expected 2", c, m_mask);
                end
            end
        end
    endtask

    // Latch schedule scoreboard built from the plane-period formula
    task automatic test_schedule(input int s, input int c, input int oe_unit, input int bcm,
                                 input int rows, input int blank, input int n);
        int t, b, r, bprev, limit;
        int pix_cnt, oe_cnt, low_run, exp_col, done, drow_exp;
        bit drow_pend;
        latch_t e;
        sel = s;
        exp_q.delete();
        t = c + blank; b = 0; r = 0; bprev = 0; limit = 0;
        for (int k = 0; k < n; k++) begin
            e.cyc = t; e.row = r; e.mask = 1 << b; e.fs = (r == 0) && (b == 0);
            e.oe_prev = (k == 0) ? 0 : (oe_unit << bprev);
            e.exact = (k > 0) && ((oe_unit << bprev) >= c);
            exp_q.push_back(e);
            limit = t;
            t = t + (((oe_unit << b) > c) ? (oe_unit << b) : c) + blank + 1;
            bprev = b;
            b = b + 1;
            if (b == bcm) begin b = 0; r = (r + 1) % rows; end
        end
        reset_dut();
        pix_cnt = 0; oe_cnt = 0; low_run = 0; exp_col = c - 1; done = 0; drow_pend = 1'b0; drow_exp = 0;
        for (int cyc = 0; (cyc <= limit + 20) && (done < n); cyc++) begin
            @(negedge clk);
            if (drow_pend) begin
                vectors++;
                if (m_drow !== drow_exp) begin
                    miscompares++; $display("FAIL sched%0d display_row cycle %0d got %0d expected %0d", s, cyc, m_drow, drow_exp);
                end
                drow_pend = 1'b0;
            end
            if (m_lat) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL sched%0d extra latch at cycle %0d", s, cyc);
                end else begin
                    e = exp_q.pop_front();
                    vectors++; if (cyc !== e.cyc) begin miscompares++; $display("FAIL sched%0d latch_cycle got %0d expected %0d", s, cyc, e.cyc); end
                    vectors++; if (m_row !== e.row) begin miscompares++; $display("FAIL sched%0d latch_row cycle %0d got %0d expected %0d", s, cyc, m_row, e.row); end
                    vectors++; if (m_mask !== e.mask) begin miscompares++; $display("FAIL sched%0d latch_mask cycle %0d got %0d expected %0d", s, cyc, m_mask, e.mask); end
                    vectors++; if (m_fs !== e.fs) begin miscompares++; $display("FAIL sched%0d frame_start cycle %0d got %0d expected %0d", s, cyc, m_fs, e.fs); end
                    vectors++; if (oe_cnt !== e.oe_prev) begin miscompares++; $display("FAIL sched%0d oe_cycles cycle %0d got %0d expected %0d", s, cyc, oe_cnt, e.oe_prev); end
                    vectors++; if (pix_cnt !== c) begin miscompares++; $display("FAIL sched%0d pixel_cycles cycle %0d got %0d expected %0d", s, cyc, pix_cnt, c); end
                    vectors++; if (m_oe !== 1'b0) begin miscompares++; $display("FAIL sched%0d oe_at_latch cycle %0d got %0d expected 0", s, cyc, m_oe); end
                    vectors++;
                    if ((low_run < blank) || (e.exact && (low_run != blank))) begin
                        miscompares++; $display("FAIL sched%0d blank_run cycle %0d got %0d expected %0d", s, cyc, low_run, blank);
                    end
                    drow_pend = 1'b1; drow_exp = e.row;
                end
                pix_cnt = 0; oe_cnt = 0; low_run = 0; exp_col = c - 1; done++;
            end else begin
                vectors++;
                if (m_fs !== 1'b0) begin miscompares++; $display("FAIL sched%0d stray_fs cycle %0d got %0d expected 0", s, cyc, m_fs); end
                if (m_pix) begin
                    pix_cnt++;
                    vectors++;
                    if (m_col !== exp_col) begin
                        miscompares++; $display("FAIL sched%0d column cycle %0d got %0d expected %0d", s, cyc, m_col, exp_col);
                    end
                    exp_col--;
                end
                if (m_oe) begin oe_cnt++; low_run = 0; end
                else low_run++;
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL sched%0d missing latches got %0d expected 0 outstanding", s, exp_q.size());
        end
    endtask

    // Reset pulse while plane 5 is lit, then the first-plane timing must repeat
    task automatic test_reset_mid_display();
        bit found;
        sel = 0;
        reset_dut();
        found = 1'b0;
        for (int i = 0; (i < 1000) && !found; i++) begin
            @(negedge clk);
            if (m_lat && (m_mask == 32)) found = 1'b1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL midreset plane5_latch got timeout expected latch"); end
        repeat (5) @(negedge clk);
        vectors++; if (m_oe !== 1'b1) begin miscompares++; $display("FAIL midreset oe_before got %0d expected 1", m_oe); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (m_oe !== 1'b0) begin miscompares++; $display("FAIL midreset oe got %0d expected 0", m_oe); end
        vectors++; if (m_lat !== 1'b0) begin miscompares++; $display("FAIL midreset latch got %0d expected 0", m_lat); end
        vectors++; if (m_pix !== 1'b0) begin miscompares++; $display("FAIL midreset pix got %0d expected 0", m_pix); end
        vectors++; if (m_mask !== 1) begin miscompares++; $display("FAIL midreset mask got %0d expected 1", m_mask); end
        vectors++; if (m_row !== 0) begin miscompares++; $display("FAIL midreset row got %0d expected 0", m_row); end
        vectors++; if (m_col !== 63) begin miscompares++; $display("FAIL midreset col got %0d expected 63", m_col); end
        rst = 1'b0;
        test_first_plane(1'b0);
    endtask

    initial begin
        test_reset();
        test_first_plane(1'b1);
        test_schedule(0, 64, 1, 6, 16, 1, 14);
        test_schedule(1, 64, 128, 6, 16, 1, 7);
        test_schedule(2, 64, 1, 2, 4, 1, 9);
        test_schedule(3, 32, 1, 6, 16, 3, 8);
        test_reset_mid_display();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
